// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types for the unified memory port arbiter
// Purpose: FSM state encoding and grant-select encoding used by mem_port_arbiter.
// Contents: state_e (IDLE, ISSUE, WAIT, RESP), gnt_e (GNT_IF, GNT_DM).
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter in front of a single-port fixed-latency memory
// Purpose: picks one of the instruction-fetch or data requesters, sequences the
//   access through the memory, captures read data and pulses the winner's ack.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                instruction read request (held until if_ack)
//   if_ack/if_rdata               one-cycle completion pulse, registered read data
//   dm_req/dm_we/dm_addr/dm_wdata data request (held until dm_ack)
//   dm_ack/dm_rdata               one-cycle completion pulse, registered read data
//   mem_en/mem_we/mem_addr/mem_wdata  one-cycle memory strobe and its qualifiers
//   mem_rdata                     memory read data, valid MEM_LAT cycles after mem_en
//   stall                         pipeline stall while any request is outstanding
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  state_e              state_q;
  gnt_e                sel_q;
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STV_W-1:0]    starve_q;
  logic                if_ack_q, dm_ack_q;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  // DM has priority unless IF has been passed over STARVE_MAX times in a row.
  logic dm_wins_d;
  assign dm_wins_d = dm_req & ~(if_req & (starve_q == STV_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= GNT_IF;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Strobes and memory qualifiers are single-cycle; they default low/zero.
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (if_req || dm_req) begin
            // The memory qualifiers double as the latched address/data and
            // are presented during ISSUE.
            mem_en_q <= 1'b1;
            state_q  <= ISSUE;
            if (dm_wins_d) begin
              sel_q       <= GNT_DM;
              we_q        <= dm_we;
              mem_we_q    <= dm_we;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
              if (if_req && (starve_q != STV_MAX)) starve_q <= starve_q + STV_W'(1);
            end else begin
              sel_q      <= GNT_IF;
              we_q       <= 1'b0;
              mem_addr_q <= if_addr;
              starve_q   <= '0;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            if (!we_q) begin
              if (sel_q == GNT_DM) dm_rdata_q <= mem_rdata;
              else                 if_rdata_q <= mem_rdata;
            end
            if (sel_q == GNT_DM) dm_ack_q <= 1'b1;
            else                 if_ack_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          // Requester drops or re-presents its req after the ack; IDLE resamples.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall     = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: MEM_LAT=2
  logic        a_if_req, a_dm_req, a_dm_we;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
  logic        a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_stall;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  // DUT B: MEM_LAT=1
  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
  logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_stall;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .stall(a_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall(b_stall)
  );

  // Memory contents: fixed function of the address, 0x100 holds 0xDEADBEEF.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  // Fixed-latency memory models; data bus is garbage outside the valid cycle.
  logic [1:0]  a_vpipe;
  logic [31:0] a_dpipe0, a_dpipe1;
  always @(posedge clk) begin
    if (rst) a_vpipe <= 2'b00;
    else     a_vpipe <= {a_vpipe[0], a_mem_en & ~a_mem_we};
    a_dpipe0 <= mem_word(a_mem_addr);
    a_dpipe1 <= a_dpipe0;
  end
  assign a_mem_rdata = a_vpipe[1] ? a_dpipe1 : 32'hBAD0BAD0;

  logic        b_vpipe;
  logic [31:0] b_dpipe0;
  always @(posedge clk) begin
    if (rst) b_vpipe <= 1'b0;
    else     b_vpipe <= b_mem_en & ~b_mem_we;
    b_dpipe0 <= mem_word(b_mem_addr);
  end
  assign b_mem_rdata = b_vpipe ? b_dpipe0 : 32'hBAD0BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;  // read data, or dm_rdata that must survive a write
  } vec_t;

  vec_t vecs[7];

  // Single access on DUT A from IDLE; mem_en expected at k=1, ack at k=4.
  task automatic run_vec(input vec_t v, input string tag);
    int en_k = -1, en_cnt = 0, ack_k = -1, wrong_ack = 0, zero_bad = 0, stall_bad = 0;
    logic        en_we = 1'b0;
    logic [31:0] en_addr = '0, en_wdata = '0;
    @(negedge clk);
    if (v.is_dm) begin
      a_dm_req = 1'b1; a_dm_we = v.we; a_dm_addr = v.addr; a_dm_wdata = v.wdata;
    end else begin
      a_if_req = 1'b1; a_if_addr = v.addr;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_mem_en) begin
        en_cnt++;
        if (en_k < 0) begin
          en_k = k; en_we = a_mem_we; en_addr = a_mem_addr; en_wdata = a_mem_wdata;
        end
      end else if (a_mem_we || a_mem_addr != 0 || a_mem_wdata != 0) begin
        zero_bad++;
      end
      if ((v.is_dm ? a_if_ack : a_dm_ack) == 1'b1) wrong_ack++;
      if ((v.is_dm ? a_dm_ack : a_if_ack) == 1'b1) begin
        if (ack_k < 0) ack_k = k; else wrong_ack++;
        if (a_stall) stall_bad++;
        if (v.is_dm) begin
          chk({tag, "_dm_rdata"}, a_dm_rdata, v.exp_rdata);
        end else begin
          chk({tag, "_if_rdata"}, a_if_rdata, v.exp_rdata);
        end
        a_if_req = 1'b0; a_dm_req = 1'b0; a_dm_we = 1'b0;
      end else if (ack_k < 0 && !a_stall) begin
        stall_bad++;
      end
    end
    chk({tag, "_en_k"}, 32'(en_k), 32'd1);
    chk({tag, "_en_cnt"}, 32'(en_cnt), 32'd1);
    chk({tag, "_mem_we"}, {31'd0, en_we}, {31'd0, v.is_dm & v.we});
    chk({tag, "_mem_addr"}, en_addr, v.addr);
    chk({tag, "_mem_wdata"}, en_wdata, v.wdata);
    chk({tag, "_ack_k"}, 32'(ack_k), 32'd4);
    chk({tag, "_wrong_ack"}, 32'(wrong_ack), 32'd0);
    chk({tag, "_idle_zero"}, 32'(zero_bad), 32'd0);
    chk({tag, "_stall"}, 32'(stall_bad), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h0200FDFF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0300, 32'h12345678,  32'h0200FDFF};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,         32'h03FCFC03};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0004FFFB};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hA5A55A5A,  32'h0004FFFB};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hFFFC0003};

    rst = 1'b1;
    a_if_req = 0; a_dm_req = 0; a_dm_we = 0; a_if_addr = 0; a_dm_addr = 0; a_dm_wdata = 0;
    b_if_req = 0; b_dm_req = 0; b_dm_we = 0; b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_outputs_a", {25'd0, a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_stall,
        (a_mem_addr != 0), (a_mem_wdata != 0)}, 32'd0);
    chk("rst_rdata_a", a_if_rdata | a_dm_rdata, 32'd0);
    chk("rst_outputs_b", {29'd0, b_if_ack, b_dm_ack, b_mem_en}, 32'd0);
    rst = 1'b0;

    // Table of single accesses (includes IF read 0x100 and DM write 0x300).
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Simultaneous requests: DM first, then IF.
    begin
      int n = 0, dm_k = -1, if_k = -1, stall_bad = 0;
      int gk[4];
      logic [31:0] ga[4];
      @(negedge clk);
      a_if_req = 1; a_if_addr = 32'h100; a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h200;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (a_mem_en && n < 4) begin gk[n] = k; ga[n] = a_mem_addr; n++; end
        if (if_k < 0 && !a_if_ack && !a_stall) stall_bad++;
        if (a_dm_ack) begin dm_k = k; a_dm_req = 0; end
        if (a_if_ack) begin if_k = k; a_if_req = 0; if (a_stall) stall_bad++; end
      end
      chk("both_grants", 32'(n), 32'd2);
      chk("both_g0_k", 32'(gk[0]), 32'd1);
      chk("both_g0_addr", ga[0], 32'h200);
      chk("both_g1_k", 32'(gk[1]), 32'd6);
      chk("both_g1_addr", ga[1], 32'h100);
      chk("both_dm_ack_k", 32'(dm_k), 32'd4);
      chk("both_if_ack_k", 32'(if_k), 32'd9);
      chk("both_if_rdata", a_if_rdata, 32'hDEADBEEF);
      chk("both_dm_rdata", a_dm_rdata, 32'h0200FDFF);
      chk("both_stall", 32'(stall_bad), 32'd0);
    end

    // Starvation: DM held continuously with IF pending -> 4 DM grants, then IF.
    begin
      int n = 0, dm_acks = 0, if_k = -1;
      logic [31:0] ga[8];
      @(negedge clk);
      a_if_req = 1; a_if_addr = 32'h100; a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h400;
      for (int k = 1; k <= 40 && if_k < 0; k++) begin
        @(negedge clk);
        if (a_mem_en && n < 8) begin ga[n] = a_mem_addr; n++; end
        if (a_dm_ack) dm_acks++;
        if (a_if_ack) begin if_k = k; a_if_req = 0; a_dm_req = 0; end
      end
      chk("starve_if_ack_seen", 32'(if_k), 32'd24);
      chk("starve_grants", 32'(n), 32'd5);
      for (int j = 0; j < 4; j++) chk($sformatf("starve_dm_g%0d", j), ga[j], 32'h400);
      chk("starve_if_g4", ga[4], 32'h100);
      chk("starve_dm_acks", 32'(dm_acks), 32'd4);
      chk("starve_cnt_cleared", 32'(dut_a.starve_q), 32'd0);
      chk("starve_dm_rdata", a_dm_rdata, 32'h0400FBFF);
    end

    // Reset during WAIT aborts the access.
    begin
      int acks = 0;
      vec_t v;
      @(negedge clk);
      @(negedge clk);
      a_if_req = 1; a_if_addr = 32'h140;
      @(negedge clk);   // ISSUE
      @(negedge clk);   // WAIT
      rst = 1; a_if_req = 0;
      @(negedge clk);
      chk("abort_outputs", {25'd0, a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_stall,
          (a_mem_addr != 0), (a_mem_wdata != 0)}, 32'd0);
      chk("abort_rdata", a_if_rdata | a_dm_rdata, 32'd0);
      rst = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (a_if_ack || a_dm_ack || a_mem_en) acks++;
      end
      chk("abort_no_ack", 32'(acks), 32'd0);
      v = '{1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF};
      run_vec(v, "post_rst");
    end

    // MEM_LAT=1 build: ack at t0+3.
    begin
      int en_k = -1, en_cnt = 0, ack_k = -1;
      @(negedge clk);
      b_if_req = 1; b_if_addr = 32'h100;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (b_mem_en) begin en_cnt++; if (en_k < 0) en_k = k; end
        if (b_if_ack) begin
          if (ack_k < 0) ack_k = k;
          chk("lat1_if_rdata", b_if_rdata, 32'hDEADBEEF);
          b_if_req = 0;
        end
      end
      chk("lat1_en_k", 32'(en_k), 32'd1);
      chk("lat1_en_cnt", 32'(en_cnt), 32'd1);
      chk("lat1_ack_k", 32'(ack_k), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
